// File: rtl/spi_slave_ctrl.sv
// SPI slave controller: receives a command word (address + R/W bit), then
// moves one or more data words between the SPI bus and a synchronous data
// memory. Owns its shift registers, bit counter and address register.
module spi_slave_ctrl #(
  parameter int ADDR_W   = 7,
  parameter int DATA_W   = 8,
  parameter bit BURST_EN = 1'b1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cs,
  input  logic              sclk_rise,
  input  logic              sclk_fall,
  input  logic              mosi,
  output logic              miso,
  output logic              miso_oe,
  output logic [ADDR_W-1:0] dm_addr,
  output logic [DATA_W-1:0] dm_din,
  input  logic [DATA_W-1:0] dm_dout,
  output logic              dm_we,
  output logic              dm_re,
  output logic              busy
);

  localparam int MAXB  = (ADDR_W + 1 > DATA_W) ? ADDR_W + 1 : DATA_W;
  localparam int CNT_W = $clog2(MAXB + 1);
  // Receive register only has to hold the bits that precede the final one of
  // a command or data word; the final bit is taken straight from mosi.
  localparam int RX_W  = (ADDR_W > DATA_W - 1) ? ADDR_W : DATA_W - 1;

  localparam logic [CNT_W-1:0] CMD_LAST  = CNT_W'(ADDR_W);
  localparam logic [CNT_W-1:0] DATA_LAST = CNT_W'(DATA_W - 1);

  typedef enum logic [2:0] {
    IDLE, CMD, RD_FETCH, RD_LOAD, DATA, DONE
  } state_e;

  state_e            state_q;
  logic [CNT_W-1:0]  cnt_q;
  logic [RX_W-1:0]   rx_sr_q;
  logic [DATA_W-1:0] tx_sr_q;
  logic [ADDR_W-1:0] dm_addr_q;
  logic [DATA_W-1:0] dm_din_q;
  logic              rw_q;
  logic              first_q;
  logic              miso_oe_q;
  logic              dm_we_q;
  logic              dm_re_q;

  logic [ADDR_W-1:0] addr_inc_d;
  logic [RX_W-1:0]   rx_shift_d;

  assign addr_inc_d = dm_addr_q + ADDR_W'(1);
  assign rx_shift_d = {rx_sr_q[RX_W-2:0], mosi};

  assign miso    = tx_sr_q[DATA_W-1];
  assign miso_oe = miso_oe_q;
  assign dm_addr = dm_addr_q;
  assign dm_din  = dm_din_q;
  assign dm_we   = dm_we_q;
  assign dm_re   = dm_re_q;
  assign busy    = (state_q != IDLE);

  // Frame sequencer: cs abort first, then rise, then fall (a fall coinciding
  // with a rise is dropped). Strobes default low so they last one clk.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      rx_sr_q   <= '0;
      tx_sr_q   <= '0;
      dm_addr_q <= '0;
      dm_din_q  <= '0;
      rw_q      <= 1'b0;
      first_q   <= 1'b0;
      miso_oe_q <= 1'b0;
      dm_we_q   <= 1'b0;
      dm_re_q   <= 1'b0;
    end else begin
      dm_we_q <= 1'b0;
      dm_re_q <= 1'b0;
      // Address advances in the clk after the write strobe so the strobe
      // itself sees the word's own address; this also happens if cs rises
      // during the strobe clk.
      if (dm_we_q) dm_addr_q <= addr_inc_d;

      if (cs) begin
        state_q   <= IDLE;
        cnt_q     <= '0;
        first_q   <= 1'b0;
        miso_oe_q <= 1'b0;
      end else begin
        case (state_q)
          IDLE: begin
            state_q <= CMD;
            cnt_q   <= '0;
          end

          CMD: begin
            if (sclk_rise) begin
              rx_sr_q <= rx_shift_d;
              if (cnt_q == CMD_LAST) begin
                dm_addr_q <= rx_sr_q[ADDR_W-1:0];
                rw_q      <= mosi;
                cnt_q     <= '0;
                if (mosi) begin
                  state_q <= RD_FETCH;
                  dm_re_q <= 1'b1;
                end else begin
                  state_q <= DATA;
                end
              end else begin
                cnt_q <= cnt_q + CNT_W'(1);
              end
            end
          end

          // dm_re is already high for this clk (raised on entry).
          RD_FETCH: state_q <= RD_LOAD;

          RD_LOAD: begin
            tx_sr_q   <= dm_dout;
            first_q   <= 1'b1;
            miso_oe_q <= 1'b1;
            state_q   <= DATA;
          end

          DATA: begin
            if (sclk_rise) begin
              rx_sr_q <= rx_shift_d;
              if (cnt_q == DATA_LAST) begin
                cnt_q <= '0;
                if (rw_q) begin
                  dm_addr_q <= addr_inc_d;
                  if (BURST_EN) begin
                    state_q <= RD_FETCH;
                    dm_re_q <= 1'b1;
                  end else begin
                    state_q   <= DONE;
                    miso_oe_q <= 1'b0;
                  end
                end else begin
                  dm_din_q <= {rx_sr_q[DATA_W-2:0], mosi};
                  dm_we_q  <= 1'b1;
                  if (!BURST_EN) state_q <= DONE;
                end
              end else begin
                cnt_q <= cnt_q + CNT_W'(1);
              end
            end else if (sclk_fall && rw_q) begin
              // The fall right after a load keeps the MSB on miso.
              if (first_q) first_q <= 1'b0;
              else         tx_sr_q <= {tx_sr_q[DATA_W-2:0], 1'b0};
            end
          end

          DONE: miso_oe_q <= 1'b0;

          default: state_q <= IDLE;
        endcase
      end
    end
  end

endmodule
